// File: rtl/net_echo_responder_if.sv
// Flit stream link between the NIC and its network-side peer.
// The master drives valid/bits_data/bits_last, the slave drives ready.
interface net_echo_responder_if;
  logic        valid;
  logic        ready;
  logic [63:0] bits_data;
  logic        bits_last;

  modport master (output valid, output bits_data, output bits_last, input ready);
  modport slave  (input valid, input bits_data, input bits_last, output ready);
endinterface

// File: rtl/net_echo_responder.sv
// Loopback peer for the NIC: stores each received frame, swaps the MAC
// addresses in the header flits and sends the frame back to the NIC.
// Frames become visible on egress only once fully buffered; frames that do
// not fit are dropped rather than backpressuring the NIC.
module net_echo_responder #(
  parameter int DEPTH = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  net_echo_responder_if.slave   net_out,
  net_echo_responder_if.master  net_in,
  input  logic                  net_macAddr_valid,
  input  logic [47:0]           net_macAddr_bits,
  output logic [31:0]           frames_echoed,
  output logic [31:0]           frames_dropped
);

  localparam int DATA_W = 64;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("net_echo_responder: DEPTH must be a power of two and at least 4");
  end

  typedef enum logic [2:0] {HDR0, HDR1, WR0, WR1, BODY, DROP} state_t;

  state_t              state;
  logic [AW:0]         wr_ptr;
  logic [AW:0]         commit_ptr;
  logic [AW:0]         rd_ptr;
  logic [AW:0]         occ;
  logic                full;
  logic [DATA_W:0]     mem [DEPTH];
  logic [DATA_W-1:0]   h0;
  logic [DATA_W-1:0]   h1;
  logic                mac_vld_s;
  logic [47:0]         mac_s;
  logic                in_hs;
  logic                we;
  logic [DATA_W:0]     wdata;
  logic                load;

  // Occupancy uses the pre-edge read pointer, so a same-edge read never frees room for a write.
  assign occ   = wr_ptr - rd_ptr;
  assign full  = (occ == DEPTH_P);
  assign in_hs = net_out.valid && net_out.ready;
  assign load  = (rd_ptr != commit_ptr) && (!net_in.valid || net_in.ready);

  // Buffer write port: rewritten header flits in WR0/WR1, body flits as they arrive.
  always_comb begin
    we    = 1'b0;
    wdata = '0;
    case (state)
      WR0: begin
        we    = !full;
        wdata = {1'b0, h1[47:0], h0[15:0]};
      end
      WR1: begin
        we    = !full;
        wdata = {1'b0, h1[63:48], (mac_vld_s ? mac_s : h0[63:16])};
      end
      BODY: begin
        we    = in_hs && !full;
        wdata = {net_out.bits_last, net_out.bits_data};
      end
      default: begin
        we    = 1'b0;
        wdata = '0;
      end
    endcase
  end

  // Flit storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clock) begin
    if (we) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Receive FSM: header capture, header rewrite, body store, commit or drop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= HDR0;
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      frames_echoed  <= '0;
      frames_dropped <= '0;
      h0             <= '0;
      h1             <= '0;
      mac_vld_s      <= 1'b0;
      mac_s          <= '0;
      net_out.ready  <= 1'b0;
    end else begin
      if (we) wr_ptr <= wr_ptr + PTR_ONE;
      case (state)
        HDR0: begin
          net_out.ready <= 1'b1;
          if (in_hs) begin
            h0 <= net_out.bits_data;
            if (net_out.bits_last) frames_dropped <= frames_dropped + 32'd1;
            else                   state          <= HDR1;
          end
        end
        HDR1: begin
          if (in_hs) begin
            h1        <= net_out.bits_data;
            mac_vld_s <= net_macAddr_valid;
            mac_s     <= net_macAddr_bits;
            if (net_out.bits_last) begin
              frames_dropped <= frames_dropped + 32'd1;
              state          <= HDR0;
            end else begin
              net_out.ready <= 1'b0;
              state         <= WR0;
            end
          end
        end
        WR0: begin
          if (full) begin
            wr_ptr         <= commit_ptr;
            frames_dropped <= frames_dropped + 32'd1;
            net_out.ready  <= 1'b1;
            state          <= DROP;
          end else begin
            state <= WR1;
          end
        end
        WR1: begin
          net_out.ready <= 1'b1;
          if (full) begin
            wr_ptr         <= commit_ptr;
            frames_dropped <= frames_dropped + 32'd1;
            state          <= DROP;
          end else begin
            state <= BODY;
          end
        end
        BODY: begin
          if (in_hs) begin
            if (full) begin
              // An overflowing last flit ends the frame here; otherwise skip the rest.
              wr_ptr         <= commit_ptr;
              frames_dropped <= frames_dropped + 32'd1;
              state          <= net_out.bits_last ? HDR0 : DROP;
            end else if (net_out.bits_last) begin
              commit_ptr    <= wr_ptr + PTR_ONE;
              frames_echoed <= frames_echoed + 32'd1;
              state         <= HDR0;
            end
          end
        end
        DROP: begin
          if (in_hs && net_out.bits_last) state <= HDR0;
        end
        default: state <= HDR0;
      endcase
    end
  end

  // Egress register: refills from committed flits whenever empty or being consumed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr           <= '0;
      net_in.valid     <= 1'b0;
      net_in.bits_data <= '0;
      net_in.bits_last <= 1'b0;
    end else if (load) begin
      {net_in.bits_last, net_in.bits_data} <= mem[rd_ptr[AW-1:0]];
      net_in.valid <= 1'b1;
      rd_ptr       <= rd_ptr + PTR_ONE;
    end else if (net_in.ready) begin
      net_in.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_net_echo_responder.sv
// Scoreboard bench for net_echo_responder: the stimulus side pushes expected
// egress flits, a negedge monitor pops and compares each egress handshake.
module tb_net_echo_responder;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mac_vld;
  logic [47:0] mac;
  logic [31:0] echoed;
  logic [31:0] dropped;

  net_echo_responder_if u_out ();
  net_echo_responder_if u_in ();

  net_echo_responder #(.DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .net_out           (u_out),
    .net_in            (u_in),
    .net_macAddr_valid (mac_vld),
    .net_macAddr_bits  (mac),
    .frames_echoed     (echoed),
    .frames_dropped    (dropped)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          rdy_mode = 0;
  logic [64:0] sb [$];
  logic        prev_stall = 1'b0;
  logic [64:0] prev_flit = '0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Random egress ready, only while random mode is selected.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rdy_mode == 2) u_in.ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: reset values, stall stability, and scoreboard pops on handshakes.
  always @(negedge clock) begin
    if (!reset) begin
      check("rst_in_valid", 65'(u_in.valid), 65'd0);
      check("rst_in_flit", {u_in.bits_last, u_in.bits_data}, 65'd0);
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 65'(u_in.valid), 65'd1);
        check("stall_flit", {u_in.bits_last, u_in.bits_data}, prev_flit);
      end
      if (u_in.valid && u_in.ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_flit: got %h want none", {u_in.bits_last, u_in.bits_data});
        end else begin
          check("egress_flit", {u_in.bits_last, u_in.bits_data}, sb.pop_front());
        end
      end
      prev_stall = u_in.valid && !u_in.ready;
      prev_flit  = {u_in.bits_last, u_in.bits_data};
    end
  end

  task automatic send_flit(input logic [63:0] d, input logic l);
    int t = 0;
    u_out.valid     = 1'b1;
    u_out.bits_data = d;
    u_out.bits_last = l;
    forever begin
      @(negedge clock);
      if (u_out.ready) break;
      t++;
      if (t > 500) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ingress_timeout: got ready=0 want ready=1");
        return;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Sends an n-flit frame; when ok is set, pushes its echoed image.
  task automatic send_frame(input int n, input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] et, input logic [63:0] base, input bit ok,
                            input bit mac_on, input logic [47:0] m);
    logic [63:0] f;
    logic        l;
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        l = (i == n - 1);
        if (i == 0)      sb.push_back({1'b0, src, 16'hBEEF});
        else if (i == 1) sb.push_back({1'b0, et, (mac_on ? m : dst)});
        else             sb.push_back({l, base + 64'(i)});
      end
    end
    for (int i = 0; i < n; i++) begin
      l = (i == n - 1);
      if (i == 0)      f = {dst, 16'hBEEF};
      else if (i == 1) f = {et, src};
      else             f = base + 64'(i);
      send_flit(f, l);
    end
    u_out.valid = 1'b0;
    u_out.bits_last = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(posedge clock);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Hard stop in case something stalls outside a bounded wait.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_out.valid     = 1'b0;
    u_out.bits_data = '0;
    u_out.bits_last = 1'b0;
    u_in.ready      = 1'b1;
    mac_vld         = 1'b0;
    mac             = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_ready", 65'(u_out.ready), 65'd0);
    check("rst_echoed", 65'(echoed), 65'd0);
    check("rst_dropped", 65'(dropped), 65'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("first_ready", 65'(u_out.ready), 65'd1);

    // Single echo with MAC configured; MAC changed after the header is taken.
    mac_vld = 1'b1;
    mac     = 48'h0A0B0C0D0E0F;
    sb.push_back({1'b0, 64'h222222222222BEEF});
    sb.push_back({1'b0, 64'h08000A0B0C0D0E0F});
    sb.push_back({1'b0, 64'hA5A5A5A5A5A5A5A5});
    sb.push_back({1'b1, 64'h5A5A5A5A5A5A5A5A});
    send_flit(64'h111111111111BEEF, 1'b0);
    send_flit(64'h0800222222222222, 1'b0);
    mac_vld = 1'b0;
    mac     = 48'hFFFFFFFFFFFF;
    send_flit(64'hA5A5A5A5A5A5A5A5, 1'b0);
    send_flit(64'h5A5A5A5A5A5A5A5A, 1'b1);
    u_out.valid = 1'b0;
    drain(100);
    check("t1_echoed", 65'(echoed), 65'd1);
    check("t1_dropped", 65'(dropped), 65'd0);

    // MAC not configured: original destination becomes the source.
    sb.push_back({1'b0, 64'h222222222222BEEF});
    sb.push_back({1'b0, 64'h0800111111111111});
    sb.push_back({1'b0, 64'hA5A5A5A5A5A5A5A5});
    sb.push_back({1'b1, 64'h5A5A5A5A5A5A5A5A});
    send_flit(64'h111111111111BEEF, 1'b0);
    send_flit(64'h0800222222222222, 1'b0);
    send_flit(64'hA5A5A5A5A5A5A5A5, 1'b0);
    send_flit(64'h5A5A5A5A5A5A5A5A, 1'b1);
    u_out.valid = 1'b0;
    drain(100);
    check("t2_echoed", 65'(echoed), 65'd2);

    // Runts: one- and two-flit frames vanish, then a normal frame echoes.
    send_frame(1, 48'h333333333333, 48'h444444444444, 16'h0800, 64'h0, 1'b0, 1'b0, 48'h0);
    send_frame(2, 48'h333333333333, 48'h444444444444, 16'h0800, 64'h0, 1'b0, 1'b0, 48'h0);
    repeat (10) @(posedge clock);
    #1;
    check("t3_dropped", 65'(dropped), 65'd2);
    check("t3_echoed_hold", 65'(echoed), 65'd2);
    send_frame(5, 48'h555555555555, 48'h666666666666, 16'h86DD, 64'hC0DE000000000000,
               1'b1, 1'b0, 48'h0);
    drain(100);
    check("t3_echoed", 65'(echoed), 65'd3);

    // Overflow: egress blocked, second 10-flit frame cannot fit.
    rdy_mode   = 1;
    u_in.ready = 1'b0;
    send_frame(10, 48'h777777777777, 48'h888888888888, 16'h0806, 64'h1000000000000000,
               1'b1, 1'b0, 48'h0);
    send_frame(10, 48'h999999999999, 48'hAAAAAAAAAAAA, 16'h0806, 64'h2000000000000000,
               1'b0, 1'b0, 48'h0);
    repeat (5) @(posedge clock);
    #1;
    check("t4_dropped", 65'(dropped), 65'd3);
    check("t4_echoed", 65'(echoed), 65'd4);
    check("t4_held_valid", 65'(u_in.valid), 65'd1);
    u_in.ready = 1'b1;
    drain(100);
    repeat (3) @(posedge clock);
    #1;
    check("t4_idle_valid", 65'(u_in.valid), 65'd0);

    // Backpressure: three back-to-back frames with random egress ready.
    rdy_mode = 2;
    send_frame(6, 48'h010101010101, 48'h020202020202, 16'h0800, 64'h3000000000000000,
               1'b1, 1'b0, 48'h0);
    send_frame(6, 48'h030303030303, 48'h040404040404, 16'h0800, 64'h4000000000000000,
               1'b1, 1'b0, 48'h0);
    send_frame(6, 48'h050505050505, 48'h060606060606, 16'h0800, 64'h5000000000000000,
               1'b1, 1'b0, 48'h0);
    drain(400);
    rdy_mode   = 0;
    u_in.ready = 1'b1;
    check("t5_echoed", 65'(echoed), 65'd7);
    check("t5_dropped", 65'(dropped), 65'd3);

    // Mid-frame reset with a committed frame still held in the buffer.
    rdy_mode   = 1;
    u_in.ready = 1'b0;
    send_frame(6, 48'h0A0A0A0A0A0A, 48'h0B0B0B0B0B0B, 16'h0800, 64'h6000000000000000,
               1'b1, 1'b0, 48'h0);
    send_flit({48'h0C0C0C0C0C0C, 16'hBEEF}, 1'b0);
    send_flit({16'h0800, 48'h0D0D0D0D0D0D}, 1'b0);
    send_flit(64'h7000000000000002, 1'b0);
    send_flit(64'h7000000000000003, 1'b0);
    reset       = 1'b0;
    u_out.valid = 1'b0;
    #1;
    check("mr_in_valid", 65'(u_in.valid), 65'd0);
    check("mr_in_flit", {u_in.bits_last, u_in.bits_data}, 65'd0);
    check("mr_out_ready", 65'(u_out.ready), 65'd0);
    check("mr_echoed", 65'(echoed), 65'd0);
    check("mr_dropped", 65'(dropped), 65'd0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    reset      = 1'b1;
    rdy_mode   = 0;
    u_in.ready = 1'b1;
    send_frame(4, 48'h0E0E0E0E0E0E, 48'h0F0F0F0F0F0F, 16'h0800, 64'h8000000000000000,
               1'b1, 1'b0, 48'h0);
    drain(100);
    check("post_rst_echoed", 65'(echoed), 65'd1);
    check("post_rst_dropped", 65'(dropped), 65'd0);
    check("sb_empty", 65'(sb.size()), 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
